// File: rtl/fetch_pkg.sv
// Shared types for the fetch next-PC generator: FSM encoding, prediction-queue entry, PC step.
package fetch_pkg;

  typedef enum logic {
    S_RUN   = 1'b0,
    S_FLUSH = 1'b1
  } state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic        taken;
    logic [31:0] target;
  } pq_entry_t;

  localparam logic [31:0] PC_INC = 32'd4;

endpackage

// File: rtl/fetch_pred_queue.sv
// Circular FIFO of in-flight BTB predictions; head is read combinationally, clear empties it.
// Push while full is accepted only together with a pop in the same cycle.
module fetch_pred_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clock,
  input  logic      reset,
  input  logic      clear,
  input  logic      push,
  input  pq_entry_t push_data,
  input  logic      pop,
  output pq_entry_t head,
  output logic      empty,
  output logic      full
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  pq_entry_t   mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        do_push;
  logic        do_pop;

  // Extra MSB distinguishes full from empty when the index bits match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head    = mem[rd_ptr[AW-1:0]];
  assign do_push = push && !clear && (!full || pop);
  assign do_pop  = pop && !clear && !empty;

  always_ff @(posedge clock) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= push_data;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

endmodule

// File: rtl/fetch_pc_gen.sv
// Fetch next-PC generator: BTB redirect, prediction tracking and mispredict flush.
// Define FETCH_RAS_EN to add the return-address stack; without it ret_hint/hit_link are ignored.
module fetch_pc_gen
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          PQ_DEPTH  = 4,
  parameter int          RAS_DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable_fetch,
  input  logic        hit,
  input  logic [31:0] hit_target,
  input  logic        hit_branch,
  input  logic        hit_link,
  input  logic        ret_hint,
  input  logic        resolve_valid,
  input  logic        resolve_taken,
  input  logic [31:0] resolve_target,
  output logic [31:0] current_pc,
  output logic        fetch_valid,
  output logic        do_flush_REG1,
  output logic        pq_full
);

  state_t      state;
  logic [31:0] prev_pc;
  pq_entry_t   pq_head;
  pq_entry_t   pq_wdata;
  logic        pq_empty;
  logic        pq_full_int;
  logic        is_run;
  logic        do_pop;
  logic        mispredict;
  logic [31:0] corrected_pc;
  logic        pred_req;
  logic        advance;
  logic        blocked;
  logic        pq_push;
  logic        redirect;
  logic [31:0] seq_pc;
  logic [31:0] next_pc;
  logic        ras_pop;
  logic [31:0] ras_val;

  assign is_run  = (state == S_RUN);
  assign do_pop  = is_run && resolve_valid && !pq_empty;
  assign pq_full = pq_full_int;
  assign seq_pc  = current_pc + PC_INC;

  // An empty queue means the resolved instruction missed in the BTB; only a taken one matters.
  always_comb begin
    mispredict   = 1'b0;
    corrected_pc = resolve_target;
    if (is_run && resolve_valid) begin
      if (pq_empty) begin
        mispredict = resolve_taken;
      end else begin
        mispredict = (pq_head.taken != resolve_taken) ||
                     (pq_head.taken && resolve_taken && (pq_head.target != resolve_target));
        if (!resolve_taken) corrected_pc = pq_head.pc + PC_INC;
      end
    end
  end

  assign pred_req = hit || ras_pop;
  assign advance  = is_run && enable_fetch && !mispredict;
  assign blocked  = pred_req && pq_full_int && !do_pop;
  assign pq_push  = advance && !blocked && pred_req;

  always_comb begin
    pq_wdata.pc     = prev_pc;
    pq_wdata.taken  = hit_branch;
    pq_wdata.target = hit_target;
    next_pc         = seq_pc;
    redirect        = 1'b0;
    if (ras_pop) begin
      pq_wdata.taken  = 1'b1;
      pq_wdata.target = ras_val;
      next_pc         = ras_val;
      redirect        = 1'b1;
    end else if (hit && hit_branch) begin
      next_pc  = hit_target;
      redirect = 1'b1;
    end
  end

  fetch_pred_queue #(
    .DEPTH (PQ_DEPTH)
  ) u_pred_queue (
    .clock     (clock),
    .reset     (reset),
    .clear     (mispredict),
    .push      (pq_push),
    .push_data (pq_wdata),
    .pop       (do_pop),
    .head      (pq_head),
    .empty     (pq_empty),
    .full      (pq_full_int)
  );

`ifdef FETCH_RAS_EN
  localparam int RW = $clog2(RAS_DEPTH);
  localparam logic [RW-1:0] TOP_ONE  = RW'(1);
  localparam logic [RW:0]   CNT_ONE  = (RW + 1)'(1);
  localparam logic [RW:0]   RAS_FULL = (RW + 1)'(RAS_DEPTH);

  logic [31:0]   ras_mem [RAS_DEPTH];
  logic [RW-1:0] ras_top;
  logic [RW:0]   ras_cnt;
  logic          ras_step;
  logic          ras_push;
  logic [RW-1:0] ras_wr_idx;

  assign ras_pop    = ret_hint && (ras_cnt != '0);
  assign ras_val    = ras_mem[ras_top];
  assign ras_step   = advance && !blocked;
  assign ras_push   = hit && hit_link;
  // Pop+push in one cycle replaces the top; a plain push past capacity overwrites the oldest.
  assign ras_wr_idx = ras_pop ? ras_top : ras_top + TOP_ONE;

  always_ff @(posedge clock) begin
    if (ras_step && ras_push) begin
      ras_mem[ras_wr_idx] <= prev_pc + PC_INC;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ras_top <= '0;
      ras_cnt <= '0;
    end else if (mispredict) begin
      ras_top <= '0;
      ras_cnt <= '0;
    end else if (ras_step) begin
      if (ras_pop && !ras_push) begin
        ras_top <= ras_top - TOP_ONE;
        ras_cnt <= ras_cnt - CNT_ONE;
      end else if (!ras_pop && ras_push) begin
        ras_top <= ras_top + TOP_ONE;
        if (ras_cnt != RAS_FULL) ras_cnt <= ras_cnt + CNT_ONE;
      end
    end
  end
`else
  logic [33:0] unused_ras;
  assign unused_ras = {hit_link, ret_hint, RAS_DEPTH[31:0]};
  assign ras_pop    = 1'b0;
  assign ras_val    = '0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= S_RUN;
      current_pc    <= RESET_PC;
      prev_pc       <= RESET_PC;
      fetch_valid   <= 1'b0;
      do_flush_REG1 <= 1'b0;
    end else begin
      do_flush_REG1 <= 1'b0;
      case (state)
        S_RUN: begin
          // Resolution acts even while stalled, so the mispredict check comes first.
          if (mispredict) begin
            state         <= S_FLUSH;
            current_pc    <= corrected_pc;
            fetch_valid   <= 1'b0;
            do_flush_REG1 <= 1'b1;
          end else if (enable_fetch) begin
            if (blocked) begin
              fetch_valid <= 1'b0;
            end else begin
              prev_pc     <= current_pc;
              current_pc  <= next_pc;
              fetch_valid <= !redirect;
            end
          end
        end
        S_FLUSH: begin
          // BTB output this cycle belongs to the wrong path and is ignored.
          state   <= S_RUN;
          prev_pc <= current_pc;
          if (enable_fetch) begin
            current_pc  <= seq_pc;
            fetch_valid <= 1'b1;
          end
        end
        default: state <= S_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Bench for fetch_pc_gen: directed scenarios then random traffic against a queue-based model.
module tb_fetch_pc_gen;

  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam int          DEPTH  = 4;
  localparam int          RDEPTH = 4;
`ifdef FETCH_RAS_EN
  localparam bit RAS_ON = 1'b1;
`else
  localparam bit RAS_ON = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic        enable_fetch, hit, hit_branch, hit_link, ret_hint;
  logic        resolve_valid, resolve_taken;
  logic [31:0] hit_target, resolve_target, current_pc;
  logic        fetch_valid, do_flush_REG1, pq_full;

  always #5 clock = ~clock;

  fetch_pc_gen #(
    .RESET_PC  (RST_PC),
    .PQ_DEPTH  (DEPTH),
    .RAS_DEPTH (RDEPTH)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .enable_fetch   (enable_fetch),
    .hit            (hit),
    .hit_target     (hit_target),
    .hit_branch     (hit_branch),
    .hit_link       (hit_link),
    .ret_hint       (ret_hint),
    .resolve_valid  (resolve_valid),
    .resolve_taken  (resolve_taken),
    .resolve_target (resolve_target),
    .current_pc     (current_pc),
    .fetch_valid    (fetch_valid),
    .do_flush_REG1  (do_flush_REG1),
    .pq_full        (pq_full)
  );

  typedef struct {
    logic [31:0] pc;
    bit          taken;
    logic [31:0] target;
  } pred_t;

  typedef struct {
    logic [31:0] pc;
    bit          fv;
    bit          fl;
    bit          full;
  } exp_t;

  pred_t       m_pq[$];
  logic [31:0] m_ras[$];
  exp_t        exp_q[$];
  logic [31:0] m_pc, m_prev;
  bit          m_fv, m_in_flush;
  int          vectors     = 0;
  int          miscompares = 0;

  // Reference: applies the next-PC rules to the inputs currently driven, one cycle at a time.
  task automatic model_step();
    pred_t       e;
    bit          mis, ret, redir;
    logic [31:0] corr, nxt, top;
    if (m_in_flush) begin
      m_in_flush = 1'b0;
      m_prev     = m_pc;
      if (enable_fetch) begin
        m_pc = m_pc + 32'd4;
        m_fv = 1'b1;
      end
    end else begin
      mis  = 1'b0;
      corr = resolve_target;
      if (resolve_valid) begin
        if (m_pq.size() == 0) begin
          mis = resolve_taken;
        end else begin
          mis = (m_pq[0].taken != resolve_taken) ||
                (resolve_taken && (m_pq[0].target != resolve_target));
          if (!resolve_taken) corr = m_pq[0].pc + 32'd4;
        end
      end
      if (mis) begin
        m_pq.delete();
        m_ras.delete();
        m_pc       = corr;
        m_fv       = 1'b0;
        m_in_flush = 1'b1;
      end else begin
        if (resolve_valid && m_pq.size() > 0) void'(m_pq.pop_front());
        if (enable_fetch) begin
          ret = RAS_ON && ret_hint && (m_ras.size() > 0);
          if ((hit || ret) && m_pq.size() == DEPTH) begin
            m_fv = 1'b0;
          end else begin
            nxt      = m_pc + 32'd4;
            redir    = 1'b0;
            e.pc     = m_prev;
            e.taken  = hit_branch;
            e.target = hit_target;
            if (ret) begin
              top      = m_ras.pop_back();
              e.taken  = 1'b1;
              e.target = top;
              nxt      = top;
              redir    = 1'b1;
            end else if (hit && hit_branch) begin
              nxt   = hit_target;
              redir = 1'b1;
            end
            if (hit || ret) m_pq.push_back(e);
            if (RAS_ON && hit && hit_link) begin
              m_ras.push_back(m_prev + 32'd4);
              if (m_ras.size() > RDEPTH) void'(m_ras.pop_front());
            end
            m_prev = m_pc;
            m_pc   = nxt;
            m_fv   = !redir;
          end
        end
      end
    end
    exp_q.push_back('{m_pc, m_fv, m_in_flush, (m_pq.size() == DEPTH)});
  endtask

  task automatic apply(input bit en, input bit h, input bit hb, input bit hl, input bit rh,
                       input logic [31:0] ht, input bit rv, input bit rtk, input logic [31:0] rtg);
    enable_fetch   = en;
    hit            = h;
    hit_branch     = hb;
    hit_link       = hl;
    ret_hint       = rh;
    hit_target     = ht;
    resolve_valid  = rv;
    resolve_taken  = rtk;
    resolve_target = rtg;
    model_step();
    @(negedge clock);
  endtask

  task automatic idle();
    apply(1, 0, 0, 0, 0, 32'h0, 0, 0, 32'h0);
  endtask

  task automatic resolve_good();
    if (m_pq.size() > 0) apply(1, 0, 0, 0, 0, 32'h0, 1, m_pq[0].taken, m_pq[0].target);
  endtask

  task automatic resolve_all();
    for (int k = 0; k < DEPTH + 1; k++) resolve_good();
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(posedge clock);
      #1;
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        vectors++;
        if (current_pc !== x.pc || fetch_valid !== x.fv || do_flush_REG1 !== x.fl || pq_full !== x.full) begin
          miscompares++;
          $display("FAIL cycle_out t=%0t: got pc=%h fv=%b flush=%b full=%b, want pc=%h fv=%b flush=%b full=%b",
                   $time, current_pc, fetch_valid, do_flush_REG1, pq_full, x.pc, x.fv, x.fl, x.full);
        end
      end
    end
  end

  initial begin : stimulus
    bit          en, h, hb, hl, rh, rv, rtk;
    logic [31:0] ht, rtg;
    reset = 1'b0;
    enable_fetch = 1'b0; hit = 1'b0; hit_branch = 1'b0; hit_link = 1'b0; ret_hint = 1'b0;
    hit_target = '0; resolve_valid = 1'b0; resolve_taken = 1'b0; resolve_target = '0;
    m_pc = RST_PC; m_prev = RST_PC; m_fv = 1'b0; m_in_flush = 1'b0;
    repeat (2) begin
      exp_q.push_back('{RST_PC, 1'b0, 1'b0, 1'b0});
      @(negedge clock);
    end
    reset = 1'b1;

    // Sequential start, BTB redirect, mispredict flush.
    idle(); idle();
    apply(1, 1, 1, 0, 0, 32'h200, 0, 0, 32'h0);
    apply(1, 0, 0, 0, 0, 32'h0, 1, 0, 32'h0);
    idle(); idle();

    // Fill the queue, stall on a fifth hit, then free a slot in the same cycle as the push.
    for (int k = 0; k < DEPTH + 2; k++) apply(1, 1, 0, 0, 0, 32'h0000_4000, 0, 0, 32'h0);
    apply(1, 1, 0, 0, 0, 32'h0000_4000, 1, 0, 32'h0);
    apply(0, 1, 0, 0, 0, 32'h0000_4000, 0, 0, 32'h0);
    idle();
    resolve_all();

    // PC wrap past the top of the address space.
    apply(1, 1, 1, 0, 0, 32'hFFFF_FFF8, 0, 0, 32'h0);
    idle(); idle(); idle();
    resolve_all();

`ifdef FETCH_RAS_EN
    apply(1, 1, 1, 0, 0, 32'h300, 0, 0, 32'h0);
    idle();
    apply(1, 1, 1, 1, 0, 32'h500, 0, 0, 32'h0);
    idle();
    apply(1, 0, 0, 0, 1, 32'h0, 0, 0, 32'h0);
    idle();
    apply(1, 1, 1, 1, 0, 32'h700, 0, 0, 32'h0);
    idle();
    apply(1, 0, 0, 0, 0, 32'h0, 1, !m_pq[0].taken, 32'h800);
    idle(); idle();
    apply(1, 0, 0, 0, 1, 32'h0, 0, 0, 32'h0);
    idle();
    resolve_all();
`endif

    for (int i = 0; i < 3000; i++) begin
      en  = m_in_flush ? 1'b1 : ($urandom_range(0, 9) != 0);
      h   = ($urandom_range(0, 2) == 0);
      hb  = $urandom_range(0, 1);
      hl  = ($urandom_range(0, 3) == 0);
      rh  = ($urandom_range(0, 4) == 0);
      ht  = 32'($urandom_range(0, 16383)) << 2;
      rv  = !m_in_flush && ($urandom_range(0, 3) == 0);
      rtk = $urandom_range(0, 1);
      rtg = 32'($urandom_range(0, 16383)) << 2;
      if (m_pq.size() > 0 && $urandom_range(0, 4) != 0) begin
        rtk = m_pq[0].taken;
        rtg = m_pq[0].target;
      end
      apply(en, h, hb, hl, rh, ht, rv, rtk, rtg);
    end
    idle();

    for (int k = 0; k < 20 && exp_q.size() > 0; k++) @(negedge clock);
    if (exp_q.size() > 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
